// File: rtl/copro_bus_master_pkg.sv
// ============================================================================
// Module : copro_bus_master_pkg
// Brief  : Shared types, constants and write byte-order table for the
//          coprocessor bus master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package copro_bus_master_pkg;

    localparam logic [7:0] REG_ADDR_DEFAULT = 8'hC0;
    localparam logic [2:0] FIRST_READ       = 3'd6;
    localparam logic [2:0] LAST_ACCESS      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_GAP    = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Operand byte sent on write access k: lo(A),hi(A),lo(B),hi(B),lo(C),hi(C)
    function automatic logic [7:0] write_byte(input logic [2:0]  k,
                                              input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [15:0] c);
        logic [7:0] r;
        case (k)
            3'd0:    r = a[7:0];
            3'd1:    r = a[15:8];
            3'd2:    r = b[7:0];
            3'd3:    r = b[15:8];
            3'd4:    r = c[7:0];
            3'd5:    r = c[15:8];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/copro_bus_master_timer.sv
// ============================================================================
// Module : bus_access_timer
// Brief  : Loadable down-counter; phase_end_o marks the last cycle of a phase.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_access_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             phase_end_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds the remaining cycles including the current one
    assign phase_end_o = (cnt_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/copro_bus_master.sv
// ============================================================================
// Module : copro_bus_master
// Brief  : Drives the ZX-UNO register bus to run one mult-and-add on the
//          coprocessor: six operand writes, two result reads, done pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module copro_bus_master
    import copro_bus_master_pkg::*;
#(
    parameter logic [7:0] REG_ADDR      = REG_ADDR_DEFAULT,
    parameter int          STROBE_CYCLES = 4,
    parameter int          GAP_CYCLES    = 2
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [15:0] c_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] d_out,
    output logic        err,
    output logic [7:0]  zxuno_regaddr,
    output logic        zxuno_regaddr_changed,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    input  logic        oe_n
);

    localparam int MAX_CYC = (GAP_CYCLES > STROBE_CYCLES) ? GAP_CYCLES : STROBE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES);
    localparam logic [TW-1:0] STROBE_LOAD = TW'(STROBE_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic [7:0]  regaddr_q, regaddr_d;
    logic        tmr_load;
    logic [TW-1:0] tmr_val;
    logic        phase_end;

    bus_access_timer #(.WIDTH(TW)) u_timer (
        .clk         (clk28),
        .rst         (rst),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .phase_end_o (phase_end)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        res_d     = res_q;
        err_d     = err_q;
        regaddr_d = regaddr_q;
        tmr_load  = 1'b0;
        tmr_val   = GAP_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    c_d       = c_in;
                    err_d     = 1'b0;
                    k_d       = 3'd0;
                    // Address is registered on acceptance so it is already valid
                    // during the SELECT cycle that flags the change.
                    regaddr_d = REG_ADDR;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                tmr_load = 1'b1;
                tmr_val  = GAP_LOAD;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                if (phase_end) begin
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LOAD;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (phase_end) begin
                    if (k_q >= FIRST_READ) begin
                        if (k_q[0]) begin
                            res_d[15:8] = din;
                        end else begin
                            res_d[7:0] = din;
                        end
                        if (oe_n) begin
                            err_d = 1'b1;
                        end
                    end
                    if (k_q == LAST_ACCESS) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d      = k_q + 3'd1;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= 3'd0;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            c_q       <= 16'h0000;
            res_q     <= 16'h0000;
            err_q     <= 1'b0;
            regaddr_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            res_q     <= res_d;
            err_q     <= err_d;
            regaddr_q <= regaddr_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once
    assign zxuno_regwr           = (state_q == ST_STROBE) && (k_q < FIRST_READ);
    assign zxuno_regrd           = (state_q == ST_STROBE) && (k_q >= FIRST_READ);
    assign zxuno_regaddr_changed = (state_q == ST_SELECT);
    assign zxuno_regaddr         = regaddr_q;
    assign dout                  = zxuno_regwr ? write_byte(k_q, a_q, b_q, c_q) : 8'h00;
    assign busy                  = (state_q != ST_IDLE);
    assign done                  = (state_q == ST_DONE);
    assign d_out                 = res_q;
    assign err                   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_copro_bus_master.sv
// ============================================================================
// Module : tb_copro_bus_master
// Brief  : Directed bench with a behavioural mult-and-add responder, bus
//          monitor and result scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_copro_bus_master;

    logic        clk28 = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in  = '0, b_in = '0, c_in = '0;
    logic        busy, done, err;
    logic [15:0] d_out;
    logic [7:0]  zxuno_regaddr, dout, din;
    logic        zxuno_regaddr_changed, zxuno_regrd, zxuno_regwr, oe_n;

    copro_bus_master dut (
        .clk28                 (clk28),
        .rst                   (rst),
        .start                 (start),
        .a_in                  (a_in),
        .b_in                  (b_in),
        .c_in                  (c_in),
        .busy                  (busy),
        .done                  (done),
        .d_out                 (d_out),
        .err                   (err),
        .zxuno_regaddr         (zxuno_regaddr),
        .zxuno_regaddr_changed (zxuno_regaddr_changed),
        .zxuno_regrd           (zxuno_regrd),
        .zxuno_regwr           (zxuno_regwr),
        .dout                  (dout),
        .din                   (din),
        .oe_n                  (oe_n)
    );

    always #5 clk28 = ~clk28;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_edge = 0;

    always @(posedge clk28) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- coprocessor responder (d = a*b>>7 + c, 9.7) ----------
    logic        stub = 1'b0;
    logic [15:0] ra = '0, rb = '0, rc = '0;
    logic [2:0]  wptr = '0;
    logic        rptr = 1'b0;
    logic        wr_q = 1'b0, rd_q = 1'b0;
    logic signed [31:0] prod;
    logic [15:0] dres;

    assign prod = $signed(ra) * $signed(rb);
    assign dres = prod[22:7] + rc;
    assign din  = stub ? 8'h5A : (rptr ? dres[15:8] : dres[7:0]);
    assign oe_n = stub ? 1'b1 : !(zxuno_regrd && zxuno_regaddr == 8'hC0);

    always @(posedge clk28) begin
        if (zxuno_regaddr_changed) begin
            wptr <= '0;
            rptr <= 1'b0;
        end else if (zxuno_regaddr == 8'hC0) begin
            if (zxuno_regwr && !wr_q) begin
                case (wptr)
                    3'd0: ra[7:0]  <= dout;
                    3'd1: ra[15:8] <= dout;
                    3'd2: rb[7:0]  <= dout;
                    3'd3: rb[15:8] <= dout;
                    3'd4: rc[7:0]  <= dout;
                    3'd5: rc[15:8] <= dout;
                    default: ;
                endcase
                wptr <= wptr + 3'd1;
            end
            if (!zxuno_regrd && rd_q) rptr <= ~rptr;
        end
        wr_q <= zxuno_regwr;
        rd_q <= zxuno_regrd;
    end

    // ---------------- bus monitor ----------------
    int chg_cnt, wr_cnt, rd_cnt, overlap, min_gap, min_len, max_len, cur_len;
    int low_run = 100;
    logic [7:0] wr_bytes [0:7];
    logic prev_wr = 1'b0, prev_rd = 1'b0;

    task automatic clear_mon();
        chg_cnt = 0; wr_cnt = 0; rd_cnt = 0; overlap = 0;
        min_gap = 100; min_len = 100; max_len = 0; cur_len = 0;
        for (int i = 0; i < 8; i++) wr_bytes[i] = 8'hxx;
    endtask

    always @(negedge clk28) begin
        if (zxuno_regaddr_changed) chg_cnt++;
        if (zxuno_regwr && zxuno_regrd) overlap++;
        if (zxuno_regwr && !prev_wr) begin
            if (wr_cnt < 8) wr_bytes[wr_cnt] = dout;
            wr_cnt++;
            if (low_run < min_gap) min_gap = low_run;
        end
        if (zxuno_regrd && !prev_rd) begin
            rd_cnt++;
            if (low_run < min_gap) min_gap = low_run;
        end
        if (zxuno_regwr || zxuno_regrd) begin
            cur_len++;
            low_run = 0;
        end else begin
            if (cur_len != 0) begin
                if (cur_len < min_len) min_len = cur_len;
                if (cur_len > max_len) max_len = cur_len;
                cur_len = 0;
            end
            low_run++;
        end
        prev_wr = zxuno_regwr;
        prev_rd = zxuno_regrd;
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [15:0] d; logic e; } exp_t;
    exp_t exp_q[$];
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk28) begin
        if (done) begin
            exp_t x;
            done_cnt++;
            done_cyc = cyc - acc_edge + 1;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done: observed done with empty scoreboard, expected none");
            end
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("d_out", {16'h0, d_out}, {16'h0, x.d});
                chk("err", {31'h0, err}, {31'h0, x.e});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] ed, input logic ee);
        exp_t x;
        x.d = ed;
        x.e = ee;
        exp_q.push_back(x);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        start = 1'b1;
        @(posedge clk28);
        #1;
        acc_edge = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int dc0 = done_cnt;
        int n   = 0;
        while (done_cnt == dc0 && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, {31'h0, done_cnt > dc0}, 32'h1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dc0;
        clear_mon();
        step(3);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err", {31'h0, err}, 0);
        chk("rst_dout16", {16'h0, d_out}, 0);
        chk("rst_regaddr", {24'h0, zxuno_regaddr}, 0);
        chk("rst_strobes", {29'h0, zxuno_regwr, zxuno_regrd, zxuno_regaddr_changed}, 0);
        chk("rst_wdata", {24'h0, dout}, 0);
        rst = 1'b0;
        step(2);

        // case 1 + bus monitor: 1.0*1.5+0.5 = 2.0
        clear_mon();
        start_op(16'h0080, 16'h00C0, 16'h0040, 16'h0100, 1'b0);
        chk("c1_busy", {31'h0, busy}, 1);
        chk("c1_changed_cycle1", {31'h0, zxuno_regaddr_changed}, 1);
        wait_done("c1_timeout");
        chk("c1_done_cycle", done_cyc, 50);
        chk("c1_chg_cnt", chg_cnt, 1);
        chk("c1_wr_cnt", wr_cnt, 6);
        chk("c1_rd_cnt", rd_cnt, 2);
        chk("c1_overlap", overlap, 0);
        chk("c1_min_len", min_len, 4);
        chk("c1_max_len", max_len, 4);
        chk("c1_min_gap", min_gap, 2);
        chk("c1_wbytes", {wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3]}, 32'h8000C000);
        chk("c1_wbytes_c", {16'h0, wr_bytes[4], wr_bytes[5]}, 32'h00004000);
        step(3);
        chk("c1_idle_busy", {31'h0, busy}, 0);
        chk("c1_regaddr_hold", {24'h0, zxuno_regaddr}, 32'hC0);

        // case 2: -1.0*2.0+0 = -2.0
        start_op(16'hFF80, 16'h0100, 16'h0000, 16'hFF00, 1'b0);
        wait_done("c2_timeout");
        step(2);

        // case 4: starts in cycles 10 and 50 ignored, start in 51 accepted
        clear_mon();
        dc0 = done_cnt;
        start_op(16'h0080, 16'h00C0, 16'h0040, 16'h0100, 1'b0);
        step(9);
        start = 1'b1;
        a_in  = 16'h7FFF;
        step(1);
        start = 1'b0;
        step(39);
        chk("c4_done_cycle50", {31'h0, done}, 1);
        start = 1'b1;
        step(1);
        chk("c4_idle_cycle51", {31'h0, busy}, 0);
        start_op(16'h0100, 16'h0100, 16'h0080, 16'h0280, 1'b0);
        chk("c4_one_done", done_cnt - dc0, 1);
        chk("c4_new_changed", {31'h0, zxuno_regaddr_changed}, 1);
        wait_done("c4_timeout");
        chk("c4_done_cycle", done_cyc, 50);
        chk("c4_two_dones", done_cnt - dc0, 2);
        chk("c4_chg_cnt", chg_cnt, 2);
        step(2);

        // case 5: reset mid-operation
        start_op(16'h0080, 16'h00C0, 16'h0040, 16'h0100, 1'b0);
        step(19);
        rst = 1'b1;
        #1;
        chk("c5_strobes", {30'h0, zxuno_regwr, zxuno_regrd}, 0);
        chk("c5_busy", {31'h0, busy}, 0);
        chk("c5_regaddr", {24'h0, zxuno_regaddr}, 0);
        chk("c5_dout16", {16'h0, d_out}, 0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        dc0 = done_cnt;
        step(60);
        chk("c5_no_done", done_cnt - dc0, 0);
        start_op(16'h0100, 16'h0100, 16'h0080, 16'h0280, 1'b0);
        wait_done("c5_timeout");
        step(2);

        // case 6: stub with oe_n stuck high
        stub = 1'b1;
        start_op(16'h1234, 16'h5678, 16'h9ABC, 16'h5A5A, 1'b1);
        wait_done("c6_timeout");
        stub = 1'b0;
        step(2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
